// File: rtl/prsim_chan_sink_pkg.sv
// Shared types and constants for the prsim four-phase channel sink.
package prsim_chan_sink_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } state_e;

endpackage

// File: rtl/prsim_sync_n.sv
// N-flop synchronizer for single-bit signals crossing from prsim into clk.
module prsim_sync_n #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/prsim_chan_sink.sv
// Four-phase bundled-data receiver: synchronizes req, acks, and queues tokens.
// Optional ack-phase watchdog enabled by defining PRSIM_CHAN_SINK_TIMEOUT_EN.
module prsim_chan_sink
    import prsim_chan_sink_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               ack_o,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    input  logic               out_ready_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               timeout_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic req_s;
    state_e state_q, state_d;
    logic ack_q, ack_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic push_c, pop_c, full_c, empty_c;
    logic [AW:0] wptr_q, rptr_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    prsim_sync_n #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (req_i),
        .q_o (req_s)
    );

    // Occupancy from registered pointers only; a same-cycle pop never frees space.
    assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_c = (wptr_q == rptr_q);
    assign pop_c   = out_ready_i && !empty_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_s) state_d = full_c ? STALL : ACK;
            STALL:   if (!full_c) state_d = ACK;
            ACK:     if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_c  = 1'b0;
        ack_d   = ack_q;
        count_d = count_q;
        if (((state_q == IDLE) && req_s && !full_c) || ((state_q == STALL) && !full_c)) begin
            push_c  = 1'b1;
            ack_d   = 1'b1;
            count_d = count_q + COUNT_W'(1);
        end else if ((state_q == ACK) && !req_s) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ack_q <= ack_d;
            if (push_c) count_q <= count_d;
        end
    end

    // Token FIFO with wrap-bit pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_c) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop_c) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    assign ack_o       = ack_q;
    assign count_o     = count_q;
    assign out_valid_o = !empty_c;
    assign out_data_o  = mem_q[rptr_q[AW-1:0]];

`ifdef PRSIM_CHAN_SINK_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] wd_cnt_q;
    logic          timeout_q;

    // Counts edges spent in ACK; flag trips on the TIMEOUT_CYC-th and sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q != ACK) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
        end else begin
            wd_cnt_q <= wd_cnt_q + TW'(1);
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_prsim_chan_sink.sv
// Scoreboard bench for prsim_chan_sink; expects TIMEOUT_CYC=8 for the watchdog case.
module tb_prsim_chan_sink;
    import prsim_chan_sink_pkg::*;

    localparam int unsigned DATA_W = 4;

`ifdef PRSIM_CHAN_SINK_TIMEOUT_EN
    localparam logic EXP_TMO = 1'b1;
`else
    localparam logic EXP_TMO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               req_i;
    logic [DATA_W-1:0]  data_i;
    logic               ack_o;
    logic               out_valid_o;
    logic [DATA_W-1:0]  out_data_o;
    logic               out_ready_i;
    logic [COUNT_W-1:0] count_o;
    logic               timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] sb[$];

    prsim_chan_sink #(
        .DATA_W(DATA_W), .SYNC_STAGES(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input int max_cyc, output int cyc);
        cyc = 0;
        while (ack_o !== val && cyc < max_cyc) begin
            step();
            cyc++;
        end
        if (ack_o !== val) check("ack_wait_timeout", 32'(ack_o), 32'(val));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = 1'b0;
        data_i = '0;
        out_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    // Full four-phase handshake; token is queued as expected output.
    task automatic send(input logic [DATA_W-1:0] d, output int rise_cyc, output int fall_cyc);
        data_i = d;
        req_i = 1'b1;
        sb.push_back(d);
        wait_ack(1'b1, 40, rise_cyc);
        req_i = 1'b0;
        wait_ack(1'b0, 40, fall_cyc);
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        repeat (6) step();
        out_ready_i = 1'b0;
        check("drain_sb_left", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(out_valid_o), 32'd0);
    endtask

    // Scoreboard pop: compare the head whenever the consumer takes a token.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("pop_unexpected_sb_size", 32'd0, 32'd1);
            end else begin
                check("pop_data", 32'(out_data_o), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int rc, fc;

        // Reset state
        do_reset();
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);

        // Single token with exact latencies
        data_i = 4'hA;
        req_i = 1'b1;
        step();
        step();
        check("single_ack_early", 32'(ack_o), 32'd0);
        step();
        check("single_ack_rise", 32'(ack_o), 32'd1);
        check("single_valid", 32'(out_valid_o), 32'd1);
        check("single_head", 32'(out_data_o), 32'hA);
        check("single_count", 32'(count_o), 32'd1);
        req_i = 1'b0;
        step();
        step();
        check("single_ack_hold", 32'(ack_o), 32'd1);
        step();
        check("single_ack_fall", 32'(ack_o), 32'd0);
        sb.push_back(4'hA);
        drain();

        // Back-to-back tokens with consumer always ready
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(DATA_W'(i), rc, fc);
            check("b2b_rise_lat", 32'(rc), 32'd3);
            check("b2b_fall_lat", 32'(fc), 32'd3);
        end
        step();
        check("b2b_count", 32'(count_o), 32'd5);
        drain();

        // FIFO full: fifth token stalls until one pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(DATA_W'(i), rc, fc);
            check("full_rise_lat", 32'(rc), 32'd3);
        end
        data_i = 4'h5;
        req_i = 1'b1;
        sb.push_back(4'h5);
        repeat (8) step();
        check("full_stall_ack", 32'(ack_o), 32'd0);
        check("full_stall_state", 32'(dut.state_q), 32'(STALL));
        check("full_count_hold", 32'(count_o), 32'd4);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("full_ack_after_pop_edge", 32'(ack_o), 32'd0);
        step();
        check("full_ack_next_edge", 32'(ack_o), 32'd1);
        check("full_count", 32'(count_o), 32'd5);
        req_i = 1'b0;
        wait_ack(1'b0, 40, fc);
        drain();

        // Reset mid-handshake with two entries queued
        do_reset();
        send(4'h7, rc, fc);
        data_i = 4'h9;
        req_i = 1'b1;
        wait_ack(1'b1, 40, rc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("midrst_ack", 32'(ack_o), 32'd0);
        check("midrst_valid", 32'(out_valid_o), 32'd0);
        check("midrst_count", 32'(count_o), 32'd0);
        sb.push_back(4'h9);
        wait_ack(1'b1, 40, rc);
        check("midrst_reaccept_lat", 32'(rc), 32'd3);
        check("midrst_reaccept_count", 32'(count_o), 32'd1);
        check("midrst_reaccept_head", 32'(out_data_o), 32'h9);
        req_i = 1'b0;
        wait_ack(1'b0, 40, fc);
        drain();

        // Watchdog while req is held high in ACK
        do_reset();
        data_i = 4'h3;
        req_i = 1'b1;
        sb.push_back(4'h3);
        wait_ack(1'b1, 40, rc);
        repeat (7) step();
        check("wd_before_limit", 32'(timeout_o), 32'd0);
        step();
        check("wd_at_limit", 32'(timeout_o), 32'(EXP_TMO));
        req_i = 1'b0;
        wait_ack(1'b0, 40, fc);
        step();
        check("wd_sticky", 32'(timeout_o), 32'(EXP_TMO));
        drain();

        // Count wrap from 0xFFFF
        do_reset();
        force dut.count_q = 16'hFFFF;
        step();
        release dut.count_q;
        step();
        check("wrap_preload", 32'(count_o), 32'hFFFF);
        send(4'h6, rc, fc);
        check("wrap_count", 32'(count_o), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
